wb_arb2: RTL and testbench

WB_ARB2 -- requirements
Module: wb_arb2

---
 rtl/wb_arb2.sv | 147 ++++++++++++++
 tb/tb_wb_arb2.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arb2.sv
// Two-master / one-slave Wishbone arbiter with round-robin grant,
// a one-cycle DONE turnaround and a saturating slave-ack timeout.
module wb_arb2 #(
  parameter int ASIZE   = 1,
  parameter int DSIZE   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  // master 0
  input  logic [ASIZE-1:0] i_m0_adr,
  input  logic             i_m0_stb,
  input  logic             i_m0_we,
  input  logic [DSIZE-1:0] i_m0_dat,
  output logic             o_m0_ack,
  output logic             o_m0_err,
  output logic [DSIZE-1:0] o_m0_dat,
  // master 1
  input  logic [ASIZE-1:0] i_m1_adr,
  input  logic             i_m1_stb,
  input  logic             i_m1_we,
  input  logic [DSIZE-1:0] i_m1_dat,
  output logic             o_m1_ack,
  output logic             o_m1_err,
  output logic [DSIZE-1:0] o_m1_dat,
  // shared slave
  output logic [ASIZE-1:0] o_s_adr,
  output logic             o_s_stb,
  output logic             o_s_we,
  output logic [DSIZE-1:0] o_s_dat,
  input  logic             i_s_ack,
  input  logic [DSIZE-1:0] i_s_dat
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;    // one-hot {m1, m0}; 2'b00 = no grant
  logic       last_q, last_d;  // 1 = master 1 was served last
  logic [7:0] cnt_q, cnt_d;    // BUS cycles elapsed since grant

  logic sel_m1;
  logic g_stb;
  logic to_lim;
  logic in_bus;

  assign sel_m1 = gnt_q[1];
  assign g_stb  = (gnt_q[1] & i_m1_stb) | (gnt_q[0] & i_m0_stb);
  assign to_lim = (cnt_q == TO_LIM);
  // Outputs are gated by reset so nothing leaks while i_rst_n is low.
  assign in_bus = (state_q == BUS) && i_rst_n;

  // State, grant, last-served and timeout counter registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: arbitration in IDLE, completion/abort/timeout in BUS
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_m0_stb || i_m1_stb) begin
          state_d = BUS;
          cnt_d   = '0;
          if (i_m0_stb && i_m1_stb) gnt_d = last_q ? 2'b01 : 2'b10;
          else                      gnt_d = i_m1_stb ? 2'b10 : 2'b01;
        end
      end
      BUS: begin
        if (!g_stb) begin
          // master withdrew: abort silently, fairness history untouched
          state_d = IDLE;
          gnt_d   = '0;
        end else if (i_s_ack || to_lim) begin
          state_d = DONE;
          gnt_d   = '0;
          last_d  = gnt_q[1];
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Output routing: slave request mux and response demux for the granted master
  always_comb begin
    logic             done_now;
    logic             err_now;
    logic [DSIZE-1:0] rdat;
    o_s_adr  = '0;
    o_s_stb  = 1'b0;
    o_s_we   = 1'b0;
    o_s_dat  = '0;
    o_m0_ack = 1'b0;
    o_m0_err = 1'b0;
    o_m0_dat = '0;
    o_m1_ack = 1'b0;
    o_m1_err = 1'b0;
    o_m1_dat = '0;
    done_now = g_stb && (i_s_ack || to_lim);
    err_now  = done_now && !i_s_ack;
    rdat     = err_now ? '1 : i_s_dat;
    if (in_bus) begin
      o_s_adr = sel_m1 ? i_m1_adr : i_m0_adr;
      o_s_we  = sel_m1 ? i_m1_we  : i_m0_we;
      o_s_dat = sel_m1 ? i_m1_dat : i_m0_dat;
      o_s_stb = g_stb && !to_lim;
      if (sel_m1) begin
        o_m1_ack = done_now;
        o_m1_err = err_now;
        o_m1_dat = rdat;
      end else begin
        o_m0_ack = done_now;
        o_m0_err = err_now;
        o_m0_dat = rdat;
      end
    end
  end

endmodule

// File: tb/tb_wb_arb2.sv
// Randomized scoreboard bench for wb_arb2: a driver issues rounds of
// master requests and queues the expected responses, a slave responder
// acks after a chosen delay, and a monitor checks every DUT response.
module tb_wb_arb2;

  localparam int ASIZE   = 1;
  localparam int DSIZE   = 8;
  localparam int TIMEOUT = 15;
  localparam int NO_ACK  = 255;

  logic             clk;
  logic             rst_n;
  logic [ASIZE-1:0] m0_adr, m1_adr;
  logic             m0_stb, m1_stb, m0_we, m1_we;
  logic [DSIZE-1:0] m0_wdat, m1_wdat;
  logic             m0_ack, m1_ack, m0_err, m1_err;
  logic [DSIZE-1:0] m0_rdat, m1_rdat;
  logic [ASIZE-1:0] s_adr;
  logic             s_stb, s_we;
  logic [DSIZE-1:0] s_wdat;
  logic             s_ack;
  logic [DSIZE-1:0] s_rdat;

  wb_arb2 #(.ASIZE(ASIZE), .DSIZE(DSIZE), .TIMEOUT(TIMEOUT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_m0_adr(m0_adr), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_dat(m0_wdat),
    .o_m0_ack(m0_ack), .o_m0_err(m0_err), .o_m0_dat(m0_rdat),
    .i_m1_adr(m1_adr), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_dat(m1_wdat),
    .o_m1_ack(m1_ack), .o_m1_err(m1_err), .o_m1_dat(m1_rdat),
    .o_s_adr (s_adr),  .o_s_stb(s_stb),   .o_s_we(s_we),   .o_s_dat(s_wdat),
    .i_s_ack (s_ack),  .i_s_dat(s_rdat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               m;
    bit               err;
    logic [DSIZE-1:0] dat;
    int               lat;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // expected slave-side request of the currently served master
  logic [ASIZE-1:0] eb_adr;
  logic             eb_we;
  logic [DSIZE-1:0] eb_dat;

  // reference arbitration history: 1 = master 1 served last
  int last_m;

  // slave responder controls
  bit               slave_en;
  int               cur_d;
  logic [DSIZE-1:0] cur_rd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave: acks cur_d cycles after the request first appears, never if
  // cur_d exceeds TIMEOUT; throws stray acks while no request is pending.
  initial begin
    bit active;
    int k;
    active = 0;
    k      = 0;
    s_ack  = 1'b0;
    s_rdat = '0;
    forever begin
      @(posedge clk); #3;
      s_ack  = 1'b0;
      s_rdat = DSIZE'($urandom);
      if (!slave_en) active = 0;
      else if (!active && s_stb) begin active = 1; k = 0; end
      else if (active) k++;
      if (active && k == cur_d) begin
        s_ack  = 1'b1;
        s_rdat = cur_rd;
        active = 0;
      end else if (active && k > TIMEOUT) begin
        active = 0;
      end
      if (!active && !s_stb && !s_ack && $urandom_range(0, 3) == 0) s_ack = 1'b1;
    end
  end

  // Monitor: compares slave request and every master response to the scoreboard
  initial begin
    int   cyc;
    int   start;
    logic prev;
    exp_t e;
    cyc   = 0;
    start = 0;
    prev  = 1'b0;
    forever begin
      @(posedge clk); #8;
      cyc++;
      if (s_stb && !prev) start = cyc;
      if (s_stb) chk("slave_req", {s_adr, s_we, s_wdat}, {eb_adr, eb_we, eb_dat});
      if (m0_ack || m1_ack || m0_err || m1_err) begin
        if (q.size() == 0) begin
          chk("unexpected_resp", {m1_ack, m0_ack, m1_err, m0_err}, 4'b0000);
        end else begin
          e = q.pop_front();
          chk("ack_sel", {m1_ack, m0_ack}, (e.m == 1) ? 2'b10 : 2'b01);
          chk("err_sel", {m1_err, m0_err}, e.err ? ((e.m == 1) ? 2'b10 : 2'b01) : 2'b00);
          chk("rd_data", (e.m == 1) ? m1_rdat : m0_rdat, e.dat);
          chk("other_data", (e.m == 1) ? m0_rdat : m1_rdat, '0);
          chk("latency", cyc - start, e.lat);
          if (e.err) chk("stb_on_timeout", s_stb, 1'b0);
        end
      end
      prev = s_stb;
    end
  end

  // Serve one master: publish expectations, wait for its ack, release stb.
  task automatic serve(input int m, input int d, input logic [DSIZE-1:0] rd);
    exp_t e;
    bit   ok;
    cur_d  = d;
    cur_rd = rd;
    eb_adr = (m == 1) ? m1_adr  : m0_adr;
    eb_we  = (m == 1) ? m1_we   : m0_we;
    eb_dat = (m == 1) ? m1_wdat : m0_wdat;
    e.m    = m;
    e.err  = (d > TIMEOUT);
    e.dat  = e.err ? '1 : rd;
    e.lat  = e.err ? TIMEOUT : d;
    q.push_back(e);
    last_m = m;
    ok = 0;
    for (int i = 0; i < TIMEOUT + 12; i++) begin
      @(posedge clk); #8;
      if ((m == 1) ? m1_ack : m0_ack) begin ok = 1; break; end
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL ack_wait: master %0d got no ack, expected one", m);
      q.delete();
    end
    @(posedge clk); #1;
    if (m == 1) m1_stb = 1'b0; else m0_stb = 1'b0;
  endtask

  task automatic run_round(input bit r0, input bit r1,
                           input logic [ASIZE-1:0] a0, input logic w0, input logic [DSIZE-1:0] d0w,
                           input logic [ASIZE-1:0] a1, input logic w1, input logic [DSIZE-1:0] d1w,
                           input int dl0, input logic [DSIZE-1:0] rd0,
                           input int dl1, input logic [DSIZE-1:0] rd1);
    int first;
    @(posedge clk); #1;
    m0_adr = a0; m0_we = w0; m0_wdat = d0w; m0_stb = r0;
    m1_adr = a1; m1_we = w1; m1_wdat = d1w; m1_stb = r1;
    if (r0 && r1) first = (last_m == 1) ? 0 : 1;
    else          first = r0 ? 0 : 1;
    if (first == 0) serve(0, dl0, rd0); else serve(1, dl1, rd1);
    if (r0 && r1) begin
      if (first == 0) serve(1, dl1, rd1); else serve(0, dl0, rd0);
    end
  endtask

  function automatic int pick_delay();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)  return $urandom_range(0, 6);
    if (r == 7) return TIMEOUT;
    if (r == 8) return TIMEOUT - 1;
    return NO_ACK;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr;
    rst_n = 1'b0; slave_en = 0; cur_d = NO_ACK; cur_rd = '0;
    m0_adr = '0; m0_stb = 1'b0; m0_we = 1'b0; m0_wdat = '0;
    m1_adr = '0; m1_stb = 1'b0; m1_we = 1'b0; m1_wdat = '0;
    eb_adr = '0; eb_we = 1'b0; eb_dat = '0;
    last_m = 1;
    repeat (3) @(posedge clk);
    #8;
    chk("reset_ctrl", {m0_ack, m1_ack, m0_err, m1_err, s_stb}, '0);
    chk("reset_data", {m0_rdat, m1_rdat, s_adr, s_we, s_wdat}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #7;
    chk("post_reset_ctrl", {m0_ack, m1_ack, m0_err, m1_err, s_stb}, '0);
    slave_en = 1;

    // tie after reset: m0, then m1; re-request: m0 again
    run_round(1, 1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1, 8'hA0, 2, 8'hA1);
    run_round(1, 1, 1'b1, 1'b0, 8'h33, 1'b0, 1'b1, 8'h44, 0, 8'hB0, 3, 8'hB1);
    // single write m0 adr 0 dat 99, ack two cycles later
    run_round(1, 0, 1'b0, 1'b1, 8'd99, 1'b0, 1'b0, 8'h00, 2, 8'h5A, 0, 8'h00);
    // read by m1 at adr 1 returning 19
    run_round(0, 1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 8'h00, 1, 8'd19);
    // slave never acks: timeout with all-ones data
    run_round(1, 0, 1'b1, 1'b0, 8'h7E, 1'b0, 1'b0, 8'h00, NO_ACK, 8'h00, 0, 8'h00);
    // ack coincident with timeout cycle is a normal ack
    run_round(0, 1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h3C, 0, 8'h00, TIMEOUT, 8'hC3);

    // m0 drops stb mid-BUS: no response, history unchanged (m1 last)
    @(posedge clk); #1;
    slave_en = 0;
    m0_adr = 1'b1; m0_we = 1'b1; m0_wdat = 8'h66; m0_stb = 1'b1;
    eb_adr = 1'b1; eb_we = 1'b1; eb_dat = 8'h66;
    repeat (3) begin @(posedge clk); #1; end
    m0_stb = 1'b0;
    #7;
    chk("abort_no_ack", {m0_ack, m0_err, m1_ack, m1_err}, '0);
    repeat (3) begin @(posedge clk); #1; end
    slave_en = 1;
    run_round(1, 1, 1'b0, 1'b1, 8'h12, 1'b1, 1'b1, 8'h34, 1, 8'h56, 1, 8'h78);

    // serve m0 so history says m0, then reset mid-BUS of m1
    run_round(1, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, 8'h9A, 0, 8'h00);
    @(posedge clk); #1;
    slave_en = 0;
    m1_adr = 1'b1; m1_we = 1'b0; m1_wdat = 8'h55; m1_stb = 1'b1;
    eb_adr = 1'b1; eb_we = 1'b0; eb_dat = 8'h55;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #7;
    chk("midbus_reset_ctrl", {m0_ack, m1_ack, m0_err, m1_err, s_stb}, '0);
    chk("midbus_reset_data", {m0_rdat, m1_rdat, s_adr, s_we, s_wdat}, '0);
    @(posedge clk); #1;
    m1_stb = 1'b0;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    last_m = 1;
    #7;
    chk("post_midbus_reset", {m0_ack, m1_ack, m0_err, m1_err, s_stb}, '0);
    @(posedge clk); #1;
    slave_en = 1;
    run_round(1, 1, 1'b1, 1'b1, 8'hE1, 1'b0, 1'b1, 8'hE2, 2, 8'hE3, 0, 8'hE4);

    // randomized rounds
    for (int n = 0; n < 60; n++) begin
      rr = $urandom_range(1, 3);
      run_round(rr[0], rr[1],
                ASIZE'($urandom), 1'($urandom), DSIZE'($urandom),
                ASIZE'($urandom), 1'($urandom), DSIZE'($urandom),
                pick_delay(), DSIZE'($urandom),
                pick_delay(), DSIZE'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    #8;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
